fifo_port_scheduler: RTL and testbench
======================================

// Module: fifo_port_scheduler
// PURPOSE
//  Shares the single command bus of the 6-bit FIFO (32-deep, one op per clock) between two
//  writers and one reader. Round-robin arbitration; issues write/pop/clear codes on the
//  FIFO's packed input pins; returns popped data to the reader with a valid strobe.
//  Tracks occupancy so writers see back-pressure; the FIFO itself has no full flag.
// PARAMETERS
//  DEPTH_BITS  5  log2 FIFO depth; must match the FIFO instance (DEPTH = 1<<DEPTH_BITS)
// PORTS
//  clk           in   1            single clock; also feeds FIFO io_in[0]
//  reset         in   1            synchronous, active-high reset
//  w0_valid      in   1            writer 0 has a word
//  w0_data       in   6            writer 0 word
//  w0_ready      out  1            writer 0 word accepted this cycle
//  w1_valid      in   1            writer 1 has a word
//  w1_data       in   6            writer 1 word
//  w1_ready      out  1            writer 1 word accepted this cycle
//  rd_req        in   1            reader requests one pop
//  rd_ack        out  1            pop issued this cycle
//  rd_valid      out  1            rd_data valid (cycle after rd_ack)
//  rd_data       out  6            popped word
//  flush         in   1            clear FIFO and counters
//  count         out  DEPTH_BITS+1 words held, 0..DEPTH
//  err           out  1            sticky: count/FIFO empty flag mismatch
//  fifo_ctl      out  7            drives FIFO io_in[7:1]
//  fifo_empty_n  in   1            FIFO io_out[1]
//  fifo_dout     in   6            FIFO io_out[7:2]
// BEHAVIOUR
//  - fifo_ctl codes ({in7..in1}): WRITE = {data[5:0],1'b1}; POP = 7'b0000110 (peek 0);
//    IDLE = 7'b0000010; CLEAR = 7'b0000000. Exactly one code per cycle, combinational from
//    state + grant.
//  - FSM: CLEAR -> RUN after 1 cycle; RUN -> CLEAR when flush. reset forces CLEAR.
//    CLEAR: drives CLEAR code, no grants, count<=0, err<=0, rr pointer<=W0.
//  - Reset values: state CLEAR, count 0, err 0, rd_valid 0, rd_data 0, all readies/rd_ack 0.
//  - Eligibility in RUN (flush low): W0 if w0_valid && count<DEPTH; W1 likewise;
//    RD if rd_req && count!=0. count==DEPTH -> both writers blocked; count==0 -> RD blocked.
//  - Arbitration: 3-way round robin W0->W1->RD->W0, starting search at rr pointer; one
//    grant max; pointer moves to the slot after the granted one; unchanged if no grant.
//  - Handshake: ready/ack high only in grant cycle, combinational from valid/req (inputs
//    must not depend on ready). Writer holds valid/data until ready.
//  - Count: +1 on write grant, -1 on pop grant, updated at the same edge the FIFO commits.
//  - Pop latency 1: rd_ack in cycle N -> rd_valid=1, rd_data=fifo_dout in cycle N+1.
//    rd_valid is a registered 1-cycle pulse; rd_data holds last popped word otherwise.
//  - flush in RUN: no grant that cycle, CLEAR code issued, next state CLEAR (2-cycle
//    outage). A pop acked the cycle before flush still delivers rd_valid.
//  - err: in RUN, set when (count!=0) != fifo_empty_n; sticky until reset/flush.
//  - Simultaneous flush and reset: reset wins (same result).
// TESTING
//  1 reset 1 cycle -> fifo_ctl=0 one cycle then 7'b0000010; count=0; all readies 0.
//  2 w0 writes 0x15, 0x2A; rd_req -> rd_ack cycle N, rd_valid cycle N+1 data 0x15, then 0x2A.
//  3 w0,w1,rd_req all held with count=4 -> grants cycle W0,W1,RD,W0...; count 4,5,6,5,6.
//  4 fill 32 words -> count=32, w0_ready/w1_ready stay 0 while valid; one pop -> next write ok.
//  5 count=0, rd_req held 3 cycles -> rd_ack 0, fifo_ctl IDLE, rd_valid 0.
//  6 count=7, flush 1 cycle -> CLEAR code, count=0, fifo_empty_n=0, err=0; writes resume.

Source files
------------

// File: rtl/fifo_port_scheduler_if.sv
// Bundles the writer, reader, status and FIFO-pin signals of fifo_port_scheduler.
// slave = scheduler side, master = clients plus the FIFO pins.
interface fifo_port_scheduler_if #(
    parameter int DEPTH_BITS = 5
);
    logic                  w0_valid;
    logic [5:0]            w0_data;
    logic                  w0_ready;
    logic                  w1_valid;
    logic [5:0]            w1_data;
    logic                  w1_ready;
    logic                  rd_req;
    logic                  rd_ack;
    logic                  rd_valid;
    logic [5:0]            rd_data;
    logic                  flush;
    logic [DEPTH_BITS:0]   count;
    logic                  err;
    logic [6:0]            fifo_ctl;
    logic                  fifo_empty_n;
    logic [5:0]            fifo_dout;

    modport slave (
        input  w0_valid, w0_data, w1_valid, w1_data, rd_req, flush,
               fifo_empty_n, fifo_dout,
        output w0_ready, w1_ready, rd_ack, rd_valid, rd_data, count, err, fifo_ctl
    );

    modport master (
        output w0_valid, w0_data, w1_valid, w1_data, rd_req, flush,
               fifo_empty_n, fifo_dout,
        input  w0_ready, w1_ready, rd_ack, rd_valid, rd_data, count, err, fifo_ctl
    );
endinterface

// File: rtl/fifo_port_scheduler.sv
// Round-robin W0/W1/RD sharing of one FIFO command bus; grants are same-cycle, pop data 1 cycle later.
// Writers stall while count==DEPTH, reader stalls while count==0; flush costs a 2-cycle outage.
module fifo_port_scheduler #(
    parameter int DEPTH_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_port_scheduler_if.slave  bus
);
    typedef enum logic { S_CLEAR = 1'b0, S_RUN = 1'b1 } state_t;
    typedef enum logic [1:0] { P_W0 = 2'd0, P_W1 = 2'd1, P_RD = 2'd2 } slot_t;

    localparam logic [DEPTH_BITS:0] DEPTH    = {1'b1, {DEPTH_BITS{1'b0}}};
    localparam logic [6:0]          CODE_POP = 7'b0000110;
    localparam logic [6:0]          CODE_IDL = 7'b0000010;
    localparam logic [6:0]          CODE_CLR = 7'b0000000;

    state_t              state, state_nxt;
    slot_t               rr, rr_nxt;
    logic [DEPTH_BITS:0] count;
    logic                err;
    logic                rd_valid;
    logic [5:0]          rd_data;
    logic                run;
    logic                el_w0, el_w1, el_rd;
    logic                g_w0, g_w1, g_rd;
    logic [6:0]          ctl;

    // Grants only while running and not being torn down by flush/reset.
    assign run   = (state == S_RUN) && !bus.flush && !reset;
    assign el_w0 = run && bus.w0_valid && (count < DEPTH);
    assign el_w1 = run && bus.w1_valid && (count < DEPTH);
    assign el_rd = run && bus.rd_req   && (count != '0);

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        g_w0      = 1'b0;
        g_w1      = 1'b0;
        g_rd      = 1'b0;
        ctl       = CODE_IDL;

        case (rr)
            P_W0: begin
                if (el_w0)      g_w0 = 1'b1;
                else if (el_w1) g_w1 = 1'b1;
                else if (el_rd) g_rd = 1'b1;
            end
            P_W1: begin
                if (el_w1)      g_w1 = 1'b1;
                else if (el_rd) g_rd = 1'b1;
                else if (el_w0) g_w0 = 1'b1;
            end
            default: begin
                if (el_rd)      g_rd = 1'b1;
                else if (el_w0) g_w0 = 1'b1;
                else if (el_w1) g_w1 = 1'b1;
            end
        endcase

        if (g_w0)      rr_nxt = P_W1;
        else if (g_w1) rr_nxt = P_RD;
        else if (g_rd) rr_nxt = P_W0;

        if (!run)      ctl = CODE_CLR;
        else if (g_w0) ctl = {bus.w0_data, 1'b1};
        else if (g_w1) ctl = {bus.w1_data, 1'b1};
        else if (g_rd) ctl = CODE_POP;

        case (state)
            S_CLEAR: begin
                state_nxt = S_RUN;
                rr_nxt    = P_W0;
            end
            default: begin
                if (bus.flush) begin
                    state_nxt = S_CLEAR;
                    rr_nxt    = P_W0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
            rr    <= P_W0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    // count tracks the FIFO commit at the same edge, so the empty-flag cross-check is exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= g_rd;
            if (g_rd) rd_data <= bus.fifo_dout;
            if (state == S_CLEAR || bus.flush) begin
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (g_w0 || g_w1) count <= count + 1'b1;
                else if (g_rd)    count <= count - 1'b1;
                if ((count != '0) != bus.fifo_empty_n) err <= 1'b1;
            end
        end
    end

    assign bus.w0_ready = g_w0;
    assign bus.w1_ready = g_w1;
    assign bus.rd_ack   = g_rd;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_data;
    assign bus.count    = count;
    assign bus.err      = err;
    assign bus.fifo_ctl = ctl;
endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Bench for fifo_port_scheduler with a behavioural 32-deep FIFO on the command pins
// and a write-order scoreboard checking every popped word.
module tb_fifo_port_scheduler;
    localparam int         DB       = 5;
    localparam int         DEPTH    = 32;
    localparam logic [6:0] CTL_IDL  = 7'b0000010;
    localparam logic [6:0] CTL_POP  = 7'b0000110;
    localparam logic [6:0] CTL_CLR  = 7'b0000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_port_scheduler_if #(.DEPTH_BITS(DB)) bus();
    fifo_port_scheduler #(.DEPTH_BITS(DB)) dut (.clk(clk), .reset(reset), .bus(bus));

    // External FIFO: in1 = write, in2 low (with in1 low) = clear, in3 = pop; dout shows the head.
    logic [5:0] mem [DEPTH];
    int  wp = 0, rp = 0, n = 0;
    bit  corrupt = 1'b0;
    always @(posedge clk) begin
        if (bus.fifo_ctl[0]) begin
            mem[wp] <= bus.fifo_ctl[6:1];
            wp      <= (wp + 1) % DEPTH;
            n       <= n + 1;
        end else if (!bus.fifo_ctl[1]) begin
            wp <= 0; rp <= 0; n <= 0;
        end else if (bus.fifo_ctl[2]) begin
            rp <= (rp + 1) % DEPTH;
            n  <= n - 1;
        end
    end
    assign bus.fifo_empty_n = (n != 0) || corrupt;
    assign bus.fifo_dout    = mem[rp];

    // Scoreboard: words queued at write grant, moved to pending at rd_ack, checked at rd_valid.
    logic [5:0] wq[$];
    logic [5:0] pend[$];
    logic [5:0] exp_word;
    bit         prev_ack = 1'b0;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            wq.delete(); pend.delete(); prev_ack = 1'b0;
        end else begin
            total++; if (bus.rd_valid !== prev_ack) begin bad++; $display("FAIL rd_valid_timing got=%b want=%b", bus.rd_valid, prev_ack); end
            if (bus.rd_valid === 1'b1 && pend.size() > 0) begin
                exp_word = pend.pop_front();
                total++; if (bus.rd_data !== exp_word) begin bad++; $display("FAIL sb_rd_data got=%h want=%h", bus.rd_data, exp_word); end
            end
            if (bus.flush === 1'b1) wq.delete();
            if (bus.w0_ready === 1'b1) wq.push_back(bus.w0_data);
            if (bus.w1_ready === 1'b1) wq.push_back(bus.w1_data);
            if (bus.rd_ack === 1'b1) begin
                if (wq.size() == 0) begin total++; bad++; $display("FAIL sb_pop_empty got=ack want=no_ack"); end
                else pend.push_back(wq.pop_front());
            end
            prev_ack = (bus.rd_ack === 1'b1);
        end
    end

    task automatic drive(input bit w0v, input logic [5:0] w0d, input bit w1v,
                         input logic [5:0] w1d, input bit rq, input bit fl);
        @(negedge clk);
        bus.w0_valid = w0v; bus.w0_data = w0d;
        bus.w1_valid = w1v; bus.w1_data = w1d;
        bus.rd_req   = rq;  bus.flush   = fl;
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1;
        bus.w0_valid = 0; bus.w1_valid = 0; bus.rd_req = 0; bus.flush = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; bus.w0_valid = 1; bus.w0_data = 6'h03; bus.w1_valid = 1; bus.rd_req = 1; bus.flush = 0;
        @(negedge clk);
        reset = 1'b0; #1;
        total++; if (bus.fifo_ctl !== CTL_CLR) begin bad++; $display("FAIL rst_ctl got=%b want=%b", bus.fifo_ctl, CTL_CLR); end
        total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count); end
        total++; if ({bus.w0_ready, bus.w1_ready, bus.rd_ack} !== 3'b000) begin bad++; $display("FAIL rst_grants got=%b want=000", {bus.w0_ready, bus.w1_ready, bus.rd_ack}); end
        total++; if ({bus.rd_valid, bus.err, bus.rd_data} !== 8'h00) begin bad++; $display("FAIL rst_regs got=%h want=00", {bus.rd_valid, bus.err, bus.rd_data}); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.fifo_ctl !== CTL_IDL) begin bad++; $display("FAIL rst_then_idle got=%b want=%b", bus.fifo_ctl, CTL_IDL); end
    endtask

    task automatic test_write_read;
        apply_reset;
        drive(1, 6'h15, 0, 0, 0, 0);
        total++; if (bus.w0_ready !== 1'b1) begin bad++; $display("FAIL wr1_ready got=%b want=1", bus.w0_ready); end
        total++; if (bus.fifo_ctl !== 7'b0101011) begin bad++; $display("FAIL wr1_ctl got=%b want=0101011", bus.fifo_ctl); end
        drive(1, 6'h2A, 0, 0, 0, 0);
        total++; if ({bus.w0_ready, bus.count} !== {1'b1, 6'd1}) begin bad++; $display("FAIL wr2 got=%b/%0d want=1/1", bus.w0_ready, bus.count); end
        drive(0, 0, 0, 0, 1, 0);
        total++; if ({bus.rd_ack, bus.fifo_ctl} !== {1'b1, CTL_POP}) begin bad++; $display("FAIL rd1_ack got=%b/%b want=1/%b", bus.rd_ack, bus.fifo_ctl, CTL_POP); end
        total++; if (bus.count !== 6'd2) begin bad++; $display("FAIL rd1_count got=%0d want=2", bus.count); end
        drive(0, 0, 0, 0, 1, 0);
        total++; if ({bus.rd_valid, bus.rd_data, bus.rd_ack} !== {1'b1, 6'h15, 1'b1}) begin bad++; $display("FAIL rd1_data got=%b/%h/%b want=1/15/1", bus.rd_valid, bus.rd_data, bus.rd_ack); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if ({bus.rd_valid, bus.rd_data, bus.count} !== {1'b1, 6'h2A, 6'd0}) begin bad++; $display("FAIL rd2_data got=%b/%h/%0d want=1/2a/0", bus.rd_valid, bus.rd_data, bus.count); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if ({bus.rd_valid, bus.rd_data} !== {1'b0, 6'h2A}) begin bad++; $display("FAIL rd_hold got=%b/%h want=0/2a", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_round_robin;
        logic [5:0] d0, d1;
        int         exp_g [4] = '{0, 1, 2, 0};
        int         exp_c [4] = '{4, 5, 6, 5};
        logic [2:0] want;
        apply_reset;
        for (int i = 0; i < 5; i++) drive(1, 6'(i + 1), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        total++; if ({bus.rd_ack, bus.count} !== {1'b1, 6'd5}) begin bad++; $display("FAIL rr_setup got=%b/%0d want=1/5", bus.rd_ack, bus.count); end
        d0 = 6'h20; d1 = 6'h30;
        for (int k = 0; k < 4; k++) begin
            drive(1, d0, 1, d1, 1, 0);
            want = 3'b001 << exp_g[k];
            total++; if ({bus.rd_ack, bus.w1_ready, bus.w0_ready} !== want) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, {bus.rd_ack, bus.w1_ready, bus.w0_ready}, want); end
            total++; if (bus.count !== 6'(exp_c[k])) begin bad++; $display("FAIL rr_count%0d got=%0d want=%0d", k, bus.count, exp_c[k]); end
            if (bus.w0_ready) d0++;
            if (bus.w1_ready) d1++;
        end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.count !== 6'd6) begin bad++; $display("FAIL rr_final got=%0d want=6", bus.count); end
    endtask

    task automatic test_full;
        logic [5:0] d0, d1;
        int         k;
        apply_reset;
        d0 = 6'h00; d1 = 6'h20; k = 0;
        while (bus.count !== 6'd32 && k < 64) begin
            drive(1, d0, 1, d1, 0, 0);
            if (bus.w0_ready) d0++;
            if (bus.w1_ready) d1++;
            k++;
        end
        total++; if (bus.count !== 6'd32) begin bad++; $display("FAIL full_reach got=%0d want=32", bus.count); end
        for (int i = 0; i < 3; i++) begin
            drive(1, d0, 1, d1, 0, 0);
            total++; if ({bus.w0_ready, bus.w1_ready, bus.fifo_ctl} !== {2'b00, CTL_IDL}) begin bad++; $display("FAIL full_block%0d got=%b%b/%b want=00/%b", i, bus.w0_ready, bus.w1_ready, bus.fifo_ctl, CTL_IDL); end
        end
        drive(1, d0, 1, d1, 1, 0);
        total++; if ({bus.rd_ack, bus.w0_ready, bus.w1_ready} !== 3'b100) begin bad++; $display("FAIL full_pop got=%b want=100", {bus.rd_ack, bus.w0_ready, bus.w1_ready}); end
        drive(1, d0, 1, d1, 0, 0);
        total++; if ({bus.w0_ready, bus.w1_ready, bus.count} !== {2'b10, 6'd31}) begin bad++; $display("FAIL full_refill got=%b%b/%0d want=10/31", bus.w0_ready, bus.w1_ready, bus.count); end
        if (bus.w0_ready) d0++;
        drive(1, d0, 1, d1, 0, 0);
        total++; if ({bus.w0_ready, bus.w1_ready, bus.count} !== {2'b00, 6'd32}) begin bad++; $display("FAIL full_again got=%b%b/%0d want=00/32", bus.w0_ready, bus.w1_ready, bus.count); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_empty_read;
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            total++; if ({bus.rd_ack, bus.rd_valid, bus.fifo_ctl} !== {2'b00, CTL_IDL}) begin bad++; $display("FAIL empty_rd%0d got=%b%b/%b want=00/%b", i, bus.rd_ack, bus.rd_valid, bus.fifo_ctl, CTL_IDL); end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush;
        apply_reset;
        for (int i = 0; i < 8; i++) drive(1, 6'h08 + 6'(i), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        total++; if ({bus.rd_ack, bus.count} !== {1'b1, 6'd8}) begin bad++; $display("FAIL fl_prepop got=%b/%0d want=1/8", bus.rd_ack, bus.count); end
        drive(1, 6'h3F, 0, 0, 1, 1);
        total++; if ({bus.fifo_ctl, bus.count} !== {CTL_CLR, 6'd7}) begin bad++; $display("FAIL fl_cycle got=%b/%0d want=%b/7", bus.fifo_ctl, bus.count, CTL_CLR); end
        total++; if ({bus.w0_ready, bus.rd_ack, bus.rd_valid, bus.rd_data} !== {3'b001, 6'h08}) begin bad++; $display("FAIL fl_inflight got=%b%b%b/%h want=001/08", bus.w0_ready, bus.rd_ack, bus.rd_valid, bus.rd_data); end
        drive(1, 6'h3F, 0, 0, 0, 0);
        total++; if ({bus.fifo_ctl, bus.count} !== {CTL_CLR, 6'd0}) begin bad++; $display("FAIL fl_clear got=%b/%0d want=%b/0", bus.fifo_ctl, bus.count, CTL_CLR); end
        total++; if ({bus.fifo_empty_n, bus.err, bus.w0_ready, bus.rd_valid} !== 4'b0000) begin bad++; $display("FAIL fl_state got=%b want=0000", {bus.fifo_empty_n, bus.err, bus.w0_ready, bus.rd_valid}); end
        drive(1, 6'h3F, 0, 0, 0, 0);
        total++; if ({bus.w0_ready, bus.fifo_ctl} !== {1'b1, 7'b1111111}) begin bad++; $display("FAIL fl_resume got=%b/%b want=1/1111111", bus.w0_ready, bus.fifo_ctl); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if ({bus.count, bus.fifo_empty_n} !== {6'd1, 1'b1}) begin bad++; $display("FAIL fl_after got=%0d/%b want=1/1", bus.count, bus.fifo_empty_n); end
    endtask

    task automatic test_err;
        apply_reset;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_init got=%b want=0", bus.err); end
        @(negedge clk); corrupt = 1'b1; #1;
        @(negedge clk); corrupt = 1'b0; #1;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_flush got=%b want=0", bus.err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w0_valid = 0; bus.w0_data = 0; bus.w1_valid = 0; bus.w1_data = 0;
        bus.rd_req = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        test_reset;
        test_write_read;
        test_round_robin;
        test_full;
        test_empty_read;
        test_flush;
        test_err;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
